twop_rf_fifo_ctrl: RTL

Synchronous FIFO controller that drives a two-port 128x32 register-file macro wrapper (one write port, one registered-read port) and presents it as a valid/ready stream FIFO. It owns the write pointer and write strobe on the push side. On the pop side it issues reads ahead of demand and covers the macro's one-cycle read latency with a 3-entry output buffer, so the consumer sees full throughput. It sits between a producer/consumer pair and the RF wrapper instance; the wrapper's ram_ctrl is tied off at the parent.

---
 rtl/twop_rf_fifo_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/twop_rf_fifo_ctrl.sv
// Stream FIFO controller over a two-port register file with a registered read port.
// Reads are issued ahead of demand into a 3-entry buffer so the consumer sees full throughput.
module twop_rf_fifo_ctrl #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_valid_i,
    input  logic [DW-1:0] push_data_i,
    output logic          push_ready_o,
    output logic          pop_valid_o,
    output logic [DW-1:0] pop_data_o,
    input  logic          pop_ready_i,
    output logic [AW:0]   count_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_wr_addr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic          rf_re_o,
    output logic [AW-1:0] rf_rd_addr_o,
    input  logic [DW-1:0] rf_rdata_i
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(2**AW);

    logic [AW:0]   wr_ptr, rd_ptr, rf_cnt;
    logic [AW:0]   wr_ptr_nx, rd_ptr_nx, count_nx;
    logic          rd_pend, rd_pend_nx;
    logic [1:0]    head, tail, buf_cnt, buf_cnt_nx;
    logic [DW-1:0] buf_mem [0:2];
    logic [AW:0]   count_q;
    logic          rf_empty, push_fire, pop_fire, rd_fire, capture;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign rf_cnt       = wr_ptr - rd_ptr;
    assign rf_empty     = (wr_ptr == rd_ptr);
    assign push_ready_o = (rf_cnt != DEPTH_V);
    assign push_fire    = push_valid_i & push_ready_o & ~flush_i;

    // Prefetch looks only at registered occupancy, so pop_ready_i never reaches rf_re_o.
    assign rd_fire  = ~rf_empty & (({1'b0, buf_cnt} + {2'b00, rd_pend}) < 3'd3) & ~flush_i;
    assign capture  = rd_pend & ~flush_i;

    assign pop_valid_o = (buf_cnt != 2'd0);
    assign pop_data_o  = buf_mem[head];
    assign pop_fire    = pop_valid_o & pop_ready_i & ~flush_i;

    assign rf_we_o      = push_fire;
    assign rf_wr_addr_o = wr_ptr[AW-1:0];
    assign rf_wdata_o   = push_data_i;
    assign rf_re_o      = rd_fire;
    assign rf_rd_addr_o = rd_ptr[AW-1:0];
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        rd_pend_nx = 1'b0;
        buf_cnt_nx = buf_cnt;
        if (flush_i) begin
            wr_ptr_nx  = '0;
            rd_ptr_nx  = '0;
            buf_cnt_nx = '0;
        end else begin
            if (push_fire)
                wr_ptr_nx = wr_ptr + 1'b1;
            if (rd_fire)
                rd_ptr_nx = rd_ptr + 1'b1;
            rd_pend_nx = rd_fire;
            case ({capture, pop_fire})
                2'b10:   buf_cnt_nx = buf_cnt + 2'd1;
                2'b01:   buf_cnt_nx = buf_cnt - 2'd1;
                default: buf_cnt_nx = buf_cnt;
            endcase
        end
        count_nx = (wr_ptr_nx - rd_ptr_nx) + (AW+1)'(rd_pend_nx) + (AW+1)'(buf_cnt_nx);
    end

    // Buffer storage is reset too so pop_data_o reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_pend <= 1'b0;
            buf_cnt <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < 3; i++)
                buf_mem[i] <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nx;
            rd_ptr  <= rd_ptr_nx;
            rd_pend <= rd_pend_nx;
            buf_cnt <= buf_cnt_nx;
            count_q <= count_nx;
            if (flush_i) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (capture) begin
                    buf_mem[tail] <= rf_rdata_i;
                    tail          <= inc3(tail);
                end
                if (pop_fire)
                    head <= inc3(head);
            end
        end
    end

endmodule
